// File: rtl/rgb_pwm_arbiter_if.sv
// Colour-request handshakes from the application (A) and status (B) sources to the RGB arbiter.
// Each colour is a packed {r,g,b} duty word; ready is a one-cycle accept pulse from the arbiter.
interface rgb_pwm_arbiter_if #(
    parameter int PWM_BITS = 8
);
    logic                    a_valid;
    logic [3*PWM_BITS-1:0]   a_rgb;
    logic                    a_ready;
    logic                    b_valid;
    logic [3*PWM_BITS-1:0]   b_rgb;
    logic                    b_ready;

    modport master (
        output a_valid, a_rgb, b_valid, b_rgb,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_rgb, b_valid, b_rgb,
        output a_ready, b_ready
    );
endinterface

// File: rtl/rgb_pwm_arbiter.sv
// Arbitrates two colour requesters onto a 3-channel PWM and debounces the LED-enable button.
// Grants only on the last cycle of a PWM period (ready is combinational there); pwm_out lags cnt by 1 cycle.
module rgb_pwm_arbiter #(
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rgb_pwm_arbiter_if.slave     req,
    input  logic                 button_in,
    output logic                 led_en,
    output logic [2:0]           pwm_out,
    output logic [1:0]           owner,
    output logic                 period_tick
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [1:0]          OWN_NONE = 2'b00;
    localparam logic [1:0]          OWN_A    = 2'b01;
    localparam logic [1:0]          OWN_B    = 2'b10;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb_t;

    logic [PWM_BITS-1:0] cnt;
    rgb_t                duty;
    logic [STARVE_W-1:0] starve_cnt;
    logic                boundary;
    logic                a_starved;
    logic                grant_a;
    logic                grant_b;

    assign boundary    = (cnt == CNT_MAX);
    assign period_tick = boundary;
    assign a_starved   = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // B normally wins; A takes over once it has lost enough consecutive boundaries.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (boundary) begin
            if (req.b_valid && !(req.a_valid && a_starved)) begin
                grant_b = 1'b1;
            end else if (req.a_valid) begin
                grant_a = 1'b1;
            end
        end
    end

    assign req.a_ready = grant_a;
    assign req.b_ready = grant_b;

    // Duty loads on the boundary edge, so the new value is live exactly from cnt == 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            duty       <= '0;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            pwm_out    <= 3'b000;
        end else begin
            cnt     <= cnt + 1'b1;
            pwm_out <= {cnt < duty.r, cnt < duty.g, cnt < duty.b};
            if (grant_a) begin
                duty  <= req.a_rgb;
                owner <= OWN_A;
            end else if (grant_b) begin
                duty  <= req.b_rgb;
                owner <= OWN_B;
            end
            if (!req.a_valid) begin
                starve_cnt <= '0;
            end else if (grant_b && !a_starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_a) begin
                starve_cnt <= '0;
            end
        end
    end

    logic            btn_s1;
    logic            btn_s2;
    logic [DB_W-1:0] db_cnt;

    // led_en only follows the synced level after an unbroken run of differing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            db_cnt <= '0;
            led_en <= 1'b0;
        end else begin
            btn_s1 <= button_in;
            btn_s2 <= btn_s1;
            if (btn_s2 == led_en) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                led_en <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rgb_pwm_arbiter.sv
// Randomised and directed bench for rgb_pwm_arbiter with a cycle-level reference model and scoreboard.
module tb_rgb_pwm_arbiter;
    localparam int PB = 4;
    localparam int DB = 8;
    localparam int SL = 2;
    localparam int PERIOD = 1 << PB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       button_in = 1'b0;
    logic       led_en;
    logic [2:0] pwm_out;
    logic [1:0] owner;
    logic       period_tick;

    always #5 clk = ~clk;

    rgb_pwm_arbiter_if #(.PWM_BITS(PB)) req ();

    rgb_pwm_arbiter #(
        .PWM_BITS(PB),
        .DEBOUNCE_CYCLES(DB),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .button_in(button_in),
        .led_en(led_en),
        .pwm_out(pwm_out),
        .owner(owner),
        .period_tick(period_tick)
    );

    typedef struct {
        bit       tick;
        bit       ar;
        bit       br;
        bit [1:0] own;
        bit [2:0] pwm;
        bit       led;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: time is "edges since reset release"; phase 15 of each period is the boundary.
    int       k;
    int       m_duty[3];
    int       m_owner;
    int       m_starve;
    bit [2:0] m_pwm;
    bit       m_led;
    bit       bh[$];

    initial begin
        exp_t e;
        int   phase;
        bit   av, bv, ga, gb, all_diff;
        int   edge_n;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                k = 0;
                m_duty = '{0, 0, 0};
                m_owner = 0;
                m_starve = 0;
                m_pwm = 3'b000;
                m_led = 1'b0;
                bh = {};
                bh.push_back(1'b0);
            end else begin
                phase = k % PERIOD;
                av = req.a_valid;
                bv = req.b_valid;
                ga = 1'b0;
                gb = 1'b0;
                if (phase == PERIOD - 1) begin
                    if (bv && !(av && m_starve >= SL)) gb = 1'b1;
                    else if (av) ga = 1'b1;
                end
                e.tick = (phase == PERIOD - 1);
                e.ar = ga;
                e.br = gb;
                e.own = 2'(m_owner);
                e.pwm = m_pwm;
                e.led = m_led;
                expq.push_back(e);

                for (int i = 0; i < 3; i++) m_pwm[2-i] = (phase < m_duty[i]);
                if (ga) begin
                    for (int i = 0; i < 3; i++) m_duty[i] = int'(req.a_rgb[(2-i)*PB +: PB]);
                    m_owner = 1;
                end else if (gb) begin
                    for (int i = 0; i < 3; i++) m_duty[i] = int'(req.b_rgb[(2-i)*PB +: PB]);
                    m_owner = 2;
                end
                if (!av) m_starve = 0;
                else if (gb) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
                else if (ga) m_starve = 0;

                // led_en flips when the last DB synchronised samples all disagree with it.
                bh.push_back(button_in);
                edge_n = k + 1;
                if (edge_n >= DB + 1) begin
                    all_diff = 1'b1;
                    for (int j = edge_n - DB - 1; j <= edge_n - 2; j++)
                        if (bh[j] == m_led) all_diff = 1'b0;
                    if (all_diff) m_led = bh[edge_n-2];
                end
                k++;
            end
        end
    end

    // Monitor: compares every live cycle's outputs against the model's queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    chk("period_tick", int'(period_tick), int'(e.tick));
                    chk("a_ready", int'(req.a_ready), int'(e.ar));
                    chk("b_ready", int'(req.b_ready), int'(e.br));
                    chk("owner", int'(owner), int'(e.own));
                    chk("pwm_out", int'(pwm_out), int'(e.pwm));
                    chk("led_en", int'(led_en), int'(e.led));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 3 * PERIOD);
        if (!period_tick) begin
            total++;
            bad++;
            $display("FAIL wait_tick_timeout actual=%0d expected<%0d", n, 3 * PERIOD);
        end
    endtask

    task automatic wait_grant_a();
        int n = 0;
        while (n < 3 * PERIOD) begin
            @(negedge clk);
            if (req.a_ready) break;
            n++;
        end
        if (n >= 3 * PERIOD) begin
            total++;
            bad++;
            $display("FAIL wait_a_ready_timeout actual=%0d expected<%0d", n, 3 * PERIOD);
        end
    endtask

    initial begin
        int  n, g;
        bit  ga, gb;
        int  seq_exp[4];
        req.a_valid = 1'b0;
        req.a_rgb   = '0;
        req.b_valid = 1'b0;
        req.b_rgb   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_owner", int'(owner), 0);
        chk("reset_led", int'(led_en), 0);
        chk("reset_tick", int'(period_tick), 0);
        reset_n = 1'b1;

        // Idle periods
        repeat (64) cyc();

        // A alone with {15,8,0}
        req.a_valid = 1'b1;
        req.a_rgb = {4'd15, 4'd8, 4'd0};
        wait_grant_a();
        cyc();
        req.a_valid = 1'b0;
        repeat (2 * PERIOD) cyc();

        // Both requesting: B, B, A (starved), B
        seq_exp = '{2, 2, 1, 2};
        req.a_valid = 1'b1;
        req.a_rgb = {4'd3, 4'd9, 4'd12};
        req.b_valid = 1'b1;
        req.b_rgb = {4'd0, 4'd0, 4'd4};
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            g = req.b_ready ? 2 : (req.a_ready ? 1 : 0);
            chk($sformatf("contention_grant%0d", i), g, seq_exp[i]);
            cyc();
        end
        req.a_valid = 1'b0;
        req.b_valid = 1'b0;
        repeat (PERIOD) cyc();

        // Button glitch then a clean press
        button_in = 1'b1;
        repeat (5) cyc();
        button_in = 1'b0;
        repeat (20) cyc();
        chk("glitch_led", int'(led_en), 0);
        button_in = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (led_en) break;
        end
        chk("led_latency", n, DB + 2);
        cyc();
        button_in = 1'b0;

        // Reset mid-period with A pending
        req.a_valid = 1'b1;
        req.a_rgb = {4'd6, 4'd1, 4'd14};
        wait_tick();
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_pwm", int'(pwm_out), 0);
        chk("midreset_owner", int'(owner), 0);
        chk("midreset_led", int'(led_en), 0);
        chk("midreset_a_ready", int'(req.a_ready), 0);
        chk("midreset_tick", int'(period_tick), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        while (n < 3 * PERIOD) begin
            @(negedge clk);
            if (req.a_ready) break;
            n++;
        end
        chk("post_reset_grant_cycle", n, PERIOD - 1);
        cyc();
        req.a_valid = 1'b0;

        // Withdrawn request before the boundary
        wait_tick();
        cyc();
        repeat (3) cyc();
        req.a_valid = 1'b1;
        req.a_rgb = {4'd2, 4'd2, 4'd2};
        repeat (7) cyc();
        req.a_valid = 1'b0;
        repeat (2 * PERIOD) cyc();
        chk("withdraw_owner", int'(owner), 1);

        // Random traffic on both requesters and the button
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ga = req.a_ready;
            gb = req.b_ready;
            @(posedge clk);
            #1;
            if (req.a_valid) begin
                if (ga) begin
                    req.a_valid = 1'($urandom_range(0, 1));
                    req.a_rgb = 12'($urandom);
                end else if ($urandom_range(0, 63) == 0) begin
                    req.a_valid = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                req.a_valid = 1'b1;
                req.a_rgb = 12'($urandom);
            end
            if (req.b_valid) begin
                if (gb) begin
                    req.b_valid = 1'($urandom_range(0, 1));
                    req.b_rgb = 12'($urandom);
                end else if ($urandom_range(0, 63) == 0) begin
                    req.b_valid = 1'b0;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                req.b_valid = 1'b1;
                req.b_rgb = 12'($urandom);
            end
            if ($urandom_range(0, 39) == 0) button_in = ~button_in;
        end
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
